// File: rtl/scaled_add_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scaled_add_pkg : mode enum and popcount shared by unary arith blocks  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package scaled_add_pkg;

  typedef enum logic [1:0] {
    SEL_EXT   = 2'd0,
    SEL_RR    = 2'd1,
    ACC_EXACT = 2'd2
  } mode_e;

  localparam int C_MAX_INUM = 256;
  localparam int C_CNT_W    = 9;

  // Callers zero-extend their stream vector to C_MAX_INUM bits and cast the result down.
  function automatic logic [C_CNT_W-1:0] popcount(input logic [C_MAX_INUM-1:0] v);
    logic [C_CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < C_MAX_INUM; i++) begin
      sum = sum + C_CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaled_add_popcnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scaled_add_popcnt : combinational ones count of INUM input streams    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module scaled_add_popcnt
  import scaled_add_pkg::*;
#(
  parameter int INUM    = 4,
  parameter int LOGINUM = $clog2(INUM)
) (
  input  logic [INUM-1:0]  in,
  output logic [LOGINUM:0] cnt
);

  localparam int C_CW = LOGINUM + 1;

  // LOGINUM+1 bits so that an all-ones input reads back as INUM.
  assign cnt = C_CW'(popcount(C_MAX_INUM'(in)));

endmodule
`default_nettype wire

// File: rtl/scaled_add.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scaled_add : unary scaled adder, out stream encodes sum(in)/INUM      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module scaled_add
  import scaled_add_pkg::*;
#(
  parameter int    INUM    = 4,
  parameter int    LOGINUM = $clog2(INUM),
  parameter mode_e MODE    = SEL_EXT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [INUM-1:0]    in,
  input  logic [LOGINUM-1:0] sel,
  output logic               out
);

  localparam int C_PAD_W = 1 << LOGINUM;

  if (MODE == SEL_EXT) begin : g_sel_ext
    logic [C_PAD_W-1:0] in_pad;
    logic               out_d;
    logic               out_q;

    // Zero padding makes any sel >= INUM pick a 0.
    assign in_pad = C_PAD_W'(in);

    always_comb begin
      out_d = out_q;
      if (en) begin
        out_d = in_pad[sel];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= 1'b0;
      end else begin
        out_q <= out_d;
      end
    end

    assign out = out_q;

  end else if (MODE == SEL_RR) begin : g_sel_rr
    localparam logic [LOGINUM-1:0] C_RR_LAST = LOGINUM'(INUM - 1);

    logic [C_PAD_W-1:0] in_pad;
    logic [LOGINUM-1:0] rr_d;
    logic [LOGINUM-1:0] rr_q;
    logic               out_d;
    logic               out_q;
    logic               unused_sel;

    assign in_pad     = C_PAD_W'(in);
    assign unused_sel = ^sel;

    // Wrap at INUM-1 so a non-power-of-two INUM never visits a padded input.
    always_comb begin
      out_d = out_q;
      rr_d  = rr_q;
      if (en) begin
        out_d = in_pad[rr_q];
        rr_d  = (rr_q == C_RR_LAST) ? '0 : rr_q + LOGINUM'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= 1'b0;
        rr_q  <= '0;
      end else begin
        out_q <= out_d;
        rr_q  <= rr_d;
      end
    end

    assign out = out_q;

  end else begin : g_acc_exact
    localparam int                 C_CW     = LOGINUM + 1;
    localparam logic [LOGINUM+1:0] C_T_INUM = (LOGINUM + 2)'(INUM);

    logic [LOGINUM:0]   cnt;
    logic [LOGINUM+1:0] t_sum;
    logic [LOGINUM:0]   acc_d;
    logic [LOGINUM:0]   acc_q;
    logic               out_d;
    logic               out_q;
    logic               unused_sel;

    assign unused_sel = ^sel;

    scaled_add_popcnt #(
      .INUM    (INUM),
      .LOGINUM (LOGINUM)
    ) u_popcnt (
      .in  (in),
      .cnt (cnt)
    );

    // acc < INUM and cnt <= INUM, so t_sum < 2*INUM fits in LOGINUM+2 bits.
    assign t_sum = {1'b0, acc_q} + {1'b0, cnt};

    always_comb begin
      out_d = out_q;
      acc_d = acc_q;
      if (en) begin
        out_d = (t_sum >= C_T_INUM);
        acc_d = C_CW'((t_sum >= C_T_INUM) ? (t_sum - C_T_INUM) : t_sum);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= 1'b0;
        acc_q <= '0;
      end else begin
        out_q <= out_d;
        acc_q <= acc_d;
      end
    end

    assign out = out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_scaled_add.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_scaled_add : directed bench for all three scaled_add modes         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_scaled_add;
  import scaled_add_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] in4   = '0;
  logic [1:0] sel4  = '0;
  logic [2:0] in3   = '0;
  logic [1:0] sel3  = '0;

  logic out_ext4, out_rr4, out_acc4, out_rr3, out_ext3;

  int n_cmp = 0;
  int n_bad = 0;

  bit exp_ext_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  scaled_add #(.INUM(4), .MODE(SEL_EXT)) u_ext4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in4), .sel(sel4), .out(out_ext4));
  scaled_add #(.INUM(4), .MODE(SEL_RR)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in4), .sel(sel4), .out(out_rr4));
  scaled_add #(.INUM(4), .MODE(ACC_EXACT)) u_acc4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in4), .sel(sel4), .out(out_acc4));
  scaled_add #(.INUM(3), .MODE(SEL_RR)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in3), .sel(sel3), .out(out_rr3));
  scaled_add #(.INUM(3), .MODE(SEL_EXT)) u_ext3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in3), .sel(sel3), .out(out_ext3));

  // Reference: round-robin as modular index, exact adder as integer quotient/remainder.
  bit m_ext4, m_rr4, m_acc4, m_rr3, m_ext3;
  int rr4_idx, rr3_idx, acc_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ext4  <= 1'b0;
      m_rr4   <= 1'b0;
      m_acc4  <= 1'b0;
      m_rr3   <= 1'b0;
      m_ext3  <= 1'b0;
      rr4_idx <= 0;
      rr3_idx <= 0;
      acc_val <= 0;
    end else if (en) begin
      m_ext4  <= in4[sel4];
      m_ext3  <= (int'(sel3) < 3) ? in3[sel3] : 1'b0;
      m_rr4   <= in4[rr4_idx];
      rr4_idx <= (rr4_idx + 1) % 4;
      m_rr3   <= in3[rr3_idx];
      rr3_idx <= (rr3_idx + 1) % 3;
      m_acc4  <= ((acc_val + $countones(in4)) / 4) != 0;
      acc_val <= (acc_val + $countones(in4)) % 4;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_ext4", out_ext4, m_ext4);
    check("model_rr4",  out_rr4,  m_rr4);
    check("model_acc4", out_acc4, m_acc4);
    check("model_rr3",  out_rr3,  m_rr3);
    check("model_ext3", out_ext3, m_ext3);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int ones4;
    int ones3;

    repeat (2) cyc();
    check("rst_ext4", out_ext4, 1'b0);
    check("rst_rr4",  out_rr4,  1'b0);
    check("rst_acc4", out_acc4, 1'b0);
    rst_n = 1'b1;

    // External select walk
    en  = 1'b1;
    in4 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      cyc();
      check("ext4_sel_walk", out_ext4, exp_ext_seq[i]);
    end

    // Round robin, INUM=4 and INUM=3
    do_reset();
    in4 = 4'b0001;
    in3 = 3'b011;
    ones4 = 0;
    ones3 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("rr4_pattern", out_rr4, (i % 4) == 0);
      check("rr3_pattern", out_rr3, (i % 3) != 2);
      ones4 += int'(out_rr4);
      if (i < 9) ones3 += int'(out_rr3);
    end
    check_int("rr4_ones12", ones4, 3);
    check_int("rr3_ones9", ones3, 6);

    // Exact accumulator patterns
    do_reset();
    in4 = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("acc_half_alt", out_acc4, (i % 2) == 1);
    end
    do_reset();
    in4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("acc_full_ones", out_acc4, 1'b1);
    end
    do_reset();
    in4 = 4'b0001;
    ones4 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("acc_quarter", out_acc4, (i == 3) || (i == 7));
      ones4 += int'(out_acc4);
    end
    check_int("acc_quarter_ones8", ones4, 2);

    // Stall holds state, inputs ignored while en=0
    do_reset();
    in4  = 4'b0111;
    sel4 = 2'd0;
    cyc();
    check("acc_pre_stall", out_acc4, 1'b0);
    check("ext_pre_stall", out_ext4, 1'b1);
    en   = 1'b0;
    in4  = 4'b0000;
    sel4 = 2'd3;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("acc_stall_hold", out_acc4, 1'b0);
      check("ext_stall_hold", out_ext4, 1'b1);
    end
    en  = 1'b1;
    in4 = 4'b0001;
    cyc();
    check("acc_resume_acc3", out_acc4, 1'b1);

    // Out-of-range external select on a 3-input block
    in3  = 3'b111;
    sel3 = 2'd3;
    cyc();
    check("ext3_sel_oob", out_ext3, 1'b0);
    sel3 = 2'd2;
    cyc();
    check("ext3_sel_top", out_ext3, 1'b1);

    // Asynchronous reset between edges
    do_reset();
    in4  = 4'b1111;
    sel4 = 2'd0;
    in3  = 3'b111;
    sel3 = 2'd0;
    repeat (3) cyc();
    check("pre_async_rr4", out_rr4, 1'b1);
    check("pre_async_acc4", out_acc4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ext4", out_ext4, 1'b0);
    check("async_rr4",  out_rr4,  1'b0);
    check("async_acc4", out_acc4, 1'b0);
    check("async_rr3",  out_rr3,  1'b0);
    check("async_ext3", out_ext3, 1'b0);
    cyc();
    rst_n = 1'b1;
    in4 = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("post_async_rr4", out_rr4, (i % 4) == 0);
      check("post_async_acc4", out_acc4, (i == 3) || (i == 7));
    end

    en = 1'b0;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
